// File: rtl/result_binarizer_if.sv
// Handshake and result bundle for result_binarizer: frame control, score stream
// and the registered per-frame result.
interface result_binarizer_if #(
    parameter int DWIDTH = 16,
    parameter int NCH    = 10
);
    localparam int IDXW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
    localparam int CW   = $clog2(NCH + 1);

    logic              start;
    logic              mode;
    logic [DWIDTH-1:0] thresh;
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic [NCH-1:0]    out_bits;
    logic [IDXW-1:0]   out_idx;
    logic [CW-1:0]     out_count;
    logic              out_hit;
    logic              done;
    logic              busy;

    modport master (
        output start, mode, thresh, in_valid, in_data,
        input  in_ready, out_bits, out_idx, out_count, out_hit, done, busy
    );

    modport slave (
        input  start, mode, thresh, in_valid, in_data,
        output in_ready, out_bits, out_idx, out_count, out_hit, done, busy
    );
endinterface

// File: rtl/result_binarizer.sv
// Binarises a serial frame of NCH class scores against a latched threshold and,
// in one-hot mode, reports only the winning class if it clears the threshold.
module result_binarizer #(
    parameter int DWIDTH = 16,
    parameter int FRAC   = 10,
    parameter int NCH    = 10,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    result_binarizer_if.slave bus
);
    localparam int IDXW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
    localparam int CW   = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_n;
    logic              mode_r;
    logic [DWIDTH-1:0] thresh_r;
    logic [DWIDTH-1:0] max_r;
    logic [IDXW-1:0]   cnt_r;
    logic [IDXW-1:0]   idx_r;
    logic [NCH-1:0]    pass_r;
    logic [NCH-1:0]    out_bits_r;
    logic [IDXW-1:0]   out_idx_r;
    logic [CW-1:0]     out_count_r;
    logic              out_hit_r;
    logic              done_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              accept_s;
    logic              last_s;
    logic [NCH-1:0]    fin_bits_s;

    function automatic logic ge_f(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) >= $signed(b);
        end else begin
            return a >= b;
        end
    endfunction

    function automatic logic gt_f(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

    function automatic logic [CW-1:0] popcount_f(input logic [NCH-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            c = c + {{(CW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next-state decode and beat acceptance
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) state_n = COLLECT;
                else           state_n = IDLE;
            end
            COLLECT: begin
                accept_s = bus.in_valid;
                last_s   = bus.in_valid && (cnt_r == IDXW'(NCH - 1));
                if (last_s) state_n = FINISH;
                else        state_n = COLLECT;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Frame result: in one-hot mode only the winner survives, and only if it passed
    always_comb begin
        fin_bits_s = {NCH{1'b0}};
        if (mode_r) begin
            fin_bits_s[idx_r] = pass_r[idx_r];
        end else begin
            fin_bits_s = pass_r;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_n;
    end

    // Frame context and per-beat accumulation; ties keep the lower channel index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r   <= 1'b0;
            thresh_r <= {DWIDTH{1'b0}};
            max_r    <= {DWIDTH{1'b0}};
            cnt_r    <= {IDXW{1'b0}};
            idx_r    <= {IDXW{1'b0}};
            pass_r   <= {NCH{1'b0}};
        end else if ((state_r == IDLE) && bus.start) begin
            mode_r   <= bus.mode;
            thresh_r <= bus.thresh;
            max_r    <= {DWIDTH{1'b0}};
            cnt_r    <= {IDXW{1'b0}};
            idx_r    <= {IDXW{1'b0}};
            pass_r   <= {NCH{1'b0}};
        end else if (accept_s) begin
            pass_r[cnt_r] <= ge_f(bus.in_data, thresh_r);
            cnt_r         <= cnt_r + IDXW'(1);
            if ((cnt_r == {IDXW{1'b0}}) || gt_f(bus.in_data, max_r)) begin
                max_r <= bus.in_data;
                idx_r <= cnt_r;
            end
        end
    end

    // Registered outputs; results only move on the FINISH cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_bits_r  <= {NCH{1'b0}};
            out_idx_r   <= {IDXW{1'b0}};
            out_count_r <= {CW{1'b0}};
            out_hit_r   <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r     <= (state_r == FINISH);
            in_ready_r <= (state_n == COLLECT);
            busy_r     <= (state_n != IDLE);
            if (state_r == FINISH) begin
                out_bits_r  <= fin_bits_s;
                out_count_r <= popcount_f(fin_bits_s);
                out_idx_r   <= idx_r;
                out_hit_r   <= |fin_bits_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_bits  = out_bits_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_count = out_count_r;
    assign bus.out_hit   = out_hit_r;
endmodule

// File: tb/tb_result_binarizer.sv
// Directed table-driven bench for result_binarizer: an unsigned and a signed
// instance share one stimulus stream; each vector selects which one is checked.
module tb_result_binarizer;
    localparam int DW  = 16;
    localparam int NCH = 4;

    typedef struct {
        bit                       sgn;
        logic                     m;
        logic [DW-1:0]            th;
        logic [NCH-1:0][DW-1:0]   d;
        logic [NCH-1:0]           bits;
        logic [1:0]               idx;
        logic [2:0]               cnt;
        logic                     hit;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   dones   = 0;
    vec_t vt [7];

    always #5 clk = ~clk;

    result_binarizer_if #(.DWIDTH(DW), .NCH(NCH)) bus_u ();
    result_binarizer_if #(.DWIDTH(DW), .NCH(NCH)) bus_s ();

    assign bus_s.start    = bus_u.start;
    assign bus_s.mode     = bus_u.mode;
    assign bus_s.thresh   = bus_u.thresh;
    assign bus_s.in_valid = bus_u.in_valid;
    assign bus_s.in_data  = bus_u.in_data;

    result_binarizer #(.DWIDTH(DW), .FRAC(10), .NCH(NCH), .SIGNED(0)) u_uns (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_u)
    );

    result_binarizer #(.DWIDTH(DW), .FRAC(10), .NCH(NCH), .SIGNED(1)) u_sgn (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus_u.done) dones++;
    endtask

    function automatic vec_t mkv(input bit sgn, input logic m, input logic [DW-1:0] th,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] c, input logic [DW-1:0] e,
                                 input logic [NCH-1:0] bits, input logic [1:0] idx,
                                 input logic [2:0] cnt, input logic hit);
        vec_t v;
        v.sgn = sgn; v.m = m; v.th = th;
        v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = e;
        v.bits = bits; v.idx = idx; v.cnt = cnt; v.hit = hit;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where done is high.
    task automatic run_frame(input vec_t v, input int gap, input bit midstart, input string tag);
        int             d0;
        logic [NCH-1:0] ob;
        logic [1:0]     oi;
        logic [2:0]     oc;
        logic           oh;
        d0 = dones;
        bus_u.start  = 1'b1;
        bus_u.mode   = v.m;
        bus_u.thresh = v.th;
        tick();
        bus_u.start  = 1'b0;
        bus_u.mode   = ~v.m;
        bus_u.thresh = ~v.th;
        chk({tag, ".ready"}, 32'(bus_u.in_ready), 32'd1);
        chk({tag, ".busy"}, 32'(bus_u.busy), 32'd1);
        for (int k = 0; k < NCH; k++) begin
            for (int g = 0; g < gap; g++) begin
                bus_u.in_valid = 1'b0;
                bus_u.start    = midstart;
                tick();
            end
            bus_u.start    = 1'b0;
            bus_u.in_valid = 1'b1;
            bus_u.in_data  = v.d[k];
            tick();
        end
        bus_u.in_valid = 1'b0;
        bus_u.in_data  = 16'hFFFF;
        chk({tag, ".fin_ready"}, 32'(bus_u.in_ready), 32'd0);
        chk({tag, ".fin_busy"}, 32'(bus_u.busy), 32'd1);
        chk({tag, ".fin_done"}, 32'(bus_u.done), 32'd0);
        tick();
        if (v.sgn) begin
            ob = bus_s.out_bits; oi = bus_s.out_idx; oc = bus_s.out_count; oh = bus_s.out_hit;
        end else begin
            ob = bus_u.out_bits; oi = bus_u.out_idx; oc = bus_u.out_count; oh = bus_u.out_hit;
        end
        chk({tag, ".done"}, 32'(bus_u.done), 32'd1);
        chk({tag, ".idle_busy"}, 32'(bus_u.busy), 32'd0);
        chk({tag, ".bits"}, 32'(ob), 32'(v.bits));
        chk({tag, ".idx"}, 32'(oi), 32'(v.idx));
        chk({tag, ".count"}, 32'(oc), 32'(v.cnt));
        chk({tag, ".hit"}, 32'(oh), 32'(v.hit));
        chk({tag, ".ndone"}, 32'(dones - d0), 32'd1);
    endtask

    initial begin
        int d0;
        reset          = 1'b1;
        bus_u.start    = 1'b0;
        bus_u.mode     = 1'b0;
        bus_u.thresh   = 16'h0000;
        bus_u.in_valid = 1'b0;
        bus_u.in_data  = 16'h0000;

        vt[0] = mkv(1'b0, 1'b0, 16'h0200, 16'h0100, 16'h0200, 16'h01FF, 16'h0400, 4'b1010, 2'd3, 3'd2, 1'b1);
        vt[1] = mkv(1'b0, 1'b1, 16'h0200, 16'h0100, 16'h0200, 16'h01FF, 16'h0400, 4'b1000, 2'd3, 3'd1, 1'b1);
        vt[2] = mkv(1'b0, 1'b1, 16'h0200, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0000, 2'd0, 3'd0, 1'b0);
        vt[3] = mkv(1'b0, 1'b1, 16'h0200, 16'h0300, 16'h0300, 16'h0000, 16'h0000, 4'b0001, 2'd0, 3'd1, 1'b1);
        vt[4] = mkv(1'b1, 1'b0, 16'hFE00, 16'hFC00, 16'h0000, 16'hFE00, 16'h8000, 4'b0110, 2'd1, 3'd2, 1'b1);
        vt[5] = mkv(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 4'b1111, 2'd3, 3'd4, 1'b1);
        vt[6] = mkv(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 4'b0101, 2'd0, 3'd2, 1'b1);

        #12;
        chk("rst.ready", 32'(bus_u.in_ready), 32'd0);
        chk("rst.busy", 32'(bus_u.busy), 32'd0);
        chk("rst.done", 32'(bus_u.done), 32'd0);
        chk("rst.bits", 32'(bus_u.out_bits), 32'd0);
        chk("rst.idx", 32'(bus_u.out_idx), 32'd0);
        chk("rst.count", 32'(bus_u.out_count), 32'd0);
        chk("rst.hit", 32'(bus_u.out_hit), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Back-to-back frames: each new start lands in the done cycle of the previous one
        for (int i = 0; i < 7; i++) begin
            run_frame(vt[i], 0, 1'b0, $sformatf("v%0d", i));
        end
        tick();

        run_frame(vt[0], 1, 1'b1, "gap");

        // in_valid pulses while idle must neither consume data nor disturb outputs
        d0 = dones;
        for (int i = 0; i < 3; i++) begin
            bus_u.in_valid = 1'b1;
            bus_u.in_data  = 16'h0400;
            tick();
        end
        bus_u.in_valid = 1'b0;
        chk("idle.bits", 32'(bus_u.out_bits), 32'(vt[0].bits));
        chk("idle.busy", 32'(bus_u.busy), 32'd0);
        chk("idle.ndone", 32'(dones - d0), 32'd0);
        run_frame(vt[3], 0, 1'b0, "post_idle");
        tick();

        // start with in_valid in the same idle cycle: the beat must not be taken
        bus_u.in_valid = 1'b1;
        bus_u.in_data  = 16'h0400;
        run_frame(vt[2], 0, 1'b0, "start_valid");
        tick();
        run_frame(vt[0], 0, 1'b0, "pre_rst");
        tick();

        // Asynchronous reset after two accepted beats
        d0 = dones;
        bus_u.start  = 1'b1;
        bus_u.mode   = 1'b0;
        bus_u.thresh = 16'h0200;
        tick();
        bus_u.start    = 1'b0;
        bus_u.in_valid = 1'b1;
        bus_u.in_data  = 16'h0400;
        tick();
        tick();
        bus_u.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst.bits", 32'(bus_u.out_bits), 32'd0);
        chk("arst.count", 32'(bus_u.out_count), 32'd0);
        chk("arst.hit", 32'(bus_u.out_hit), 32'd0);
        chk("arst.idx", 32'(bus_u.out_idx), 32'd0);
        chk("arst.busy", 32'(bus_u.busy), 32'd0);
        chk("arst.ready", 32'(bus_u.in_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("arst.ndone", 32'(dones - d0), 32'd0);
        chk("arst.hold_bits", 32'(bus_u.out_bits), 32'd0);
        run_frame(vt[0], 0, 1'b0, "post_rst");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
